// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Brief    : Shared encodings for the mini-CPU control unit and ALU:
//             CPU states, opcodes and instruction field bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // CPU sequencer states, as presented on stateCPU
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_CALC   = 3'd4,
    ST_WAIT   = 3'd5,
    ST_STORE  = 3'd6,
    ST_SHOW   = 3'd7
  } cpu_state_t;

  // Instruction opcodes
  typedef enum logic [2:0] {
    OP_LOAD    = 3'd0,
    OP_ADD     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_SUB     = 3'd3,
    OP_SUBI    = 3'd4,
    OP_MUL     = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_DISPLAY = 3'd7
  } opcode_t;

  // Instruction field bit positions
  localparam int c_INSTR_W = 18;
  localparam int c_OPC_MSB = 17;
  localparam int c_OPC_LSB = 15;
  localparam int c_DST_MSB = 14;
  localparam int c_DST_LSB = 11;
  localparam int c_S1_MSB  = 10;
  localparam int c_S1_LSB  = 7;
  localparam int c_S2_MSB  = 6;
  localparam int c_S2_LSB  = 3;
  localparam int c_SGN_BIT = 6;
  localparam int c_IMM_MSB = 5;
  localparam int c_IMM_LSB = 0;

  // Opcodes whose result is written back into the register RAM
  function automatic logic op_writes_ram(input logic [2:0] op);
    return (op != OP_CLEAR) && (op != OP_DISPLAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/module_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module   : module_btn_edge
//  Brief    : Two-flop synchronizer plus rising-edge detector for an
//             asynchronous push-button. Emits a registered one-cycle pulse
//             three clocks after the button rises.
//  Revision : 1.0 - initial release
// ============================================================================
module module_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic r_sync0;
  logic r_sync1;
  logic r_prev;
  logic r_pulse;

  // Synchronize the raw button and register a single-cycle rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync0 <= btn;
      r_sync1 <= r_sync0;
      r_prev  <= r_sync1;
      r_pulse <= r_sync1 & ~r_prev;
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/module_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : module_control_unit
//  Brief    : Mini-CPU sequencer. Latches one instruction per send press,
//             handshakes with the ALU, sequences RAM read/write and the LCD
//             refresh. Optional handshake watchdog enabled by defining the
//             macro CTRL_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module module_control_unit
  import ctrl_pkg::*;
#(
  parameter int READ_LAT    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power,
  input  logic        send,
  input  logic [17:0] instr,
  input  logic        decoded,
  input  logic        calculated,
  input  logic        lcd_done,
  output logic [2:0]  stateCPU,
  output logic [2:0]  opcode,
  output logic        sinalImm,
  output logic [5:0]  Imm,
  output logic [3:0]  addr_dst,
  output logic [3:0]  addr_s1,
  output logic [3:0]  addr_s2,
  output logic        ram_we,
  output logic        ram_clear,
  output logic        lcd_update,
  output logic        err
);

  // Catch out-of-range configurations at elaboration
  if (READ_LAT < 1 || READ_LAT > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("module_control_unit: READ_LAT must be 1..15 and TIMEOUT_CYC >= 1");
  end

  // READ counter is preloaded with READ_LAT-1 so READ lasts READ_LAT cycles
  localparam logic [3:0] c_READ_LOAD = 4'(READ_LAT - 1);

  cpu_state_t r_state;
  logic [2:0] r_opcode;
  logic       r_sinal;
  logic [5:0] r_imm;
  logic [3:0] r_dst;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic       r_ram_we;
  logic       r_ram_clear;
  logic       r_lcd_update;
  logic [3:0] r_cnt;
  logic       w_send_pulse;

`ifdef CTRL_TIMEOUT_EN
  localparam int c_WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYC - 1);
  logic [c_WD_W-1:0] r_wd;
  logic              r_err;
`endif

  module_btn_edge u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (send),
    .pulse (w_send_pulse)
  );

  // Main sequencer: state, latched instruction fields and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_opcode     <= 3'd0;
      r_sinal      <= 1'b0;
      r_imm        <= 6'd0;
      r_dst        <= 4'd0;
      r_s1         <= 4'd0;
      r_s2         <= 4'd0;
      r_ram_we     <= 1'b0;
      r_ram_clear  <= 1'b0;
      r_lcd_update <= 1'b0;
      r_cnt        <= 4'd0;
`ifdef CTRL_TIMEOUT_EN
      r_wd         <= '0;
      r_err        <= 1'b0;
`endif
    end else if (!power) begin
      // Power-off overrides everything; latched fields are kept
      r_state      <= ST_OFF;
      r_ram_we     <= 1'b0;
      r_ram_clear  <= 1'b0;
      r_lcd_update <= 1'b0;
      r_cnt        <= 4'd0;
`ifdef CTRL_TIMEOUT_EN
      r_wd         <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_ram_we     <= 1'b0;
      r_ram_clear  <= 1'b0;
      r_lcd_update <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      r_wd         <= '0;
`endif
      case (r_state)
        ST_OFF: r_state <= ST_FETCH;

        ST_FETCH: begin
          if (w_send_pulse) begin
            r_opcode <= instr[c_OPC_MSB:c_OPC_LSB];
            r_dst    <= instr[c_DST_MSB:c_DST_LSB];
            r_s1     <= instr[c_S1_MSB:c_S1_LSB];
            r_s2     <= instr[c_S2_MSB:c_S2_LSB];
            r_sinal  <= instr[c_SGN_BIT];
            r_imm    <= instr[c_IMM_MSB:c_IMM_LSB];
            r_state  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (decoded) begin
            r_cnt   <= c_READ_LOAD;
            r_state <= ST_READ;
          end
`ifdef CTRL_TIMEOUT_EN
          else if (r_wd == c_WD_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_FETCH;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end

        ST_READ: begin
          if (r_cnt == 4'd0) r_state <= ST_CALC;
          else               r_cnt   <= r_cnt - 4'd1;
        end

        ST_CALC: begin
          if (calculated) begin
            r_state <= ST_WAIT;
          end
`ifdef CTRL_TIMEOUT_EN
          else if (r_wd == c_WD_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_FETCH;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end

        // Strobes are set on the WAIT->STORE edge so they are high only in STORE
        ST_WAIT: begin
          r_ram_we    <= op_writes_ram(r_opcode);
          r_ram_clear <= (r_opcode == OP_CLEAR);
          r_state     <= ST_STORE;
        end

        ST_STORE: begin
          r_lcd_update <= 1'b1;
          r_state      <= ST_SHOW;
        end

        ST_SHOW: begin
          if (lcd_done) begin
            r_state <= ST_FETCH;
          end
`ifdef CTRL_TIMEOUT_EN
          else if (r_wd == c_WD_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_FETCH;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end

        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign stateCPU   = r_state;
  assign opcode     = r_opcode;
  assign sinalImm   = r_sinal;
  assign Imm        = r_imm;
  assign addr_dst   = r_dst;
  assign addr_s1    = r_s1;
  assign addr_s2    = r_s2;
  assign ram_we     = r_ram_we;
  assign ram_clear  = r_ram_clear;
  assign lcd_update = r_lcd_update;

`ifdef CTRL_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_module_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_module_control_unit
//  Brief    : Self-checking bench for module_control_unit with a small
//             ALU/LCD responder and a store-event scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_module_control_unit;

  localparam logic [2:0] S_OFF = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_READ = 3'd3,
                         S_CALC = 3'd4, S_WAIT = 3'd5, S_STORE = 3'd6, S_SHOW = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power = 1'b0;
  logic        send = 1'b0;
  logic [17:0] instr = '0;
  logic        decoded = 1'b0;
  logic        calculated = 1'b0;
  logic        lcd_done = 1'b0;
  logic [2:0]  stateCPU;
  logic [2:0]  opcode;
  logic        sinalImm;
  logic [5:0]  Imm;
  logic [3:0]  addr_dst;
  logic [3:0]  addr_s1;
  logic [3:0]  addr_s2;
  logic        ram_we;
  logic        ram_clear;
  logic        lcd_update;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  bit calc_stuck = 1'b0;

  typedef struct packed {
    logic       we;
    logic       clr;
    logic [3:0] dst;
  } store_t;
  store_t store_q[$];

  module_control_unit #(.READ_LAT(2), .TIMEOUT_CYC(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power      (power),
    .send       (send),
    .instr      (instr),
    .decoded    (decoded),
    .calculated (calculated),
    .lcd_done   (lcd_done),
    .stateCPU   (stateCPU),
    .opcode     (opcode),
    .sinalImm   (sinalImm),
    .Imm        (Imm),
    .addr_dst   (addr_dst),
    .addr_s1    (addr_s1),
    .addr_s2    (addr_s2),
    .ram_we     (ram_we),
    .ram_clear  (ram_clear),
    .lcd_update (lcd_update),
    .err        (err)
  );

  always #5 clk = ~clk;

  // ALU / LCD responder: answers one cycle after the DUT enters the waiting state
  always @(posedge clk) begin
    #1;
    decoded    = (stateCPU == S_DECODE);
    calculated = (stateCPU == S_CALC) && !calc_stuck;
    lcd_done   = (stateCPU == S_SHOW);
  end

  // Scoreboard: every STORE cycle pops the expected strobe/address record
  store_t got_store;
  store_t exp_store;
  always @(negedge clk) begin
    if (rst_n && stateCPU == S_STORE) begin
      got_store = {ram_we, ram_clear, addr_dst};
      n_checks++;
      if (store_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_store: got we=%0b clr=%0b dst=%0d, required no STORE", ram_we, ram_clear, addr_dst);
      end else begin
        exp_store = store_q.pop_front();
        if (got_store !== exp_store) begin
          n_fail++;
          $display("FAIL store_record: got %b, required %b", got_store, exp_store);
        end
      end
    end
    if (rst_n && stateCPU != S_STORE && (ram_we || ram_clear)) begin
      n_checks++;
      n_fail++;
      $display("FAIL stray_strobe: we=%0b clr=%0b in state %0d, required 0", ram_we, ram_clear, stateCPU);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (stateCPU == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [17:0] mk_instr(input logic [2:0] op, input logic [3:0] d,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] lo);
    return {op, d, a, b, lo};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; power = 1'b0; send = 1'b0;
    tick(); tick();
    n_checks++;
    if ({stateCPU, ram_we, ram_clear, lcd_update, err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got st=%0d we=%0b clr=%0b lcd=%0b err=%0b, required all 0", stateCPU, ram_we, ram_clear, lcd_update, err);
    end
    n_checks++;
    if ({opcode, sinalImm, Imm, addr_dst, addr_s1, addr_s2} !== 22'b0) begin
      n_fail++; $display("FAIL reset_fields: got %h, required 0", {opcode, sinalImm, Imm, addr_dst, addr_s1, addr_s2});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (stateCPU !== S_OFF) begin n_fail++; $display("FAIL off_without_power: got %0d, required 0", stateCPU); end
    power = 1'b1;
    tick();
    n_checks++;
    if (stateCPU !== S_FETCH || lcd_update !== 1'b0) begin
      n_fail++; $display("FAIL power_on_fetch: got st=%0d lcd=%0b, required st=1 lcd=0", stateCPU, lcd_update);
    end
    tick(); tick(); tick();
  endtask

  // One instruction with a full state trace check
  task automatic run_traced(input logic [17:0] ins, input logic we, input logic clr, input string name);
    logic [2:0] exp_st[$];
    logic       exp_lcd[$];
    logic [2:0] es;
    logic       el;
    exp_st  = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_READ, S_READ, S_CALC, S_WAIT, S_STORE, S_SHOW, S_FETCH};
    exp_lcd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    instr = ins;
    store_q.push_back({we, clr, ins[14:11]});
    send = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      es = exp_st.pop_front();
      el = exp_lcd.pop_front();
      n_checks++;
      if (stateCPU !== es || lcd_update !== el) begin
        n_fail++; $display("FAIL %s_trace[%0d]: got st=%0d lcd=%0b, required st=%0d lcd=%0b", name, i, stateCPU, lcd_update, es, el);
      end
    end
    send = 1'b0;
    n_checks++;
    if ({opcode, addr_dst, addr_s1, addr_s2, sinalImm, Imm} !== {ins[17:15], ins[14:11], ins[10:7], ins[6:3], ins[6], ins[5:0]}) begin
      n_fail++; $display("FAIL %s_fields: got op=%0d d=%0d a=%0d b=%0d s=%0b imm=%0d, required instr %h", name, opcode, addr_dst, addr_s1, addr_s2, sinalImm, Imm, ins);
    end
    n_checks++;
    if (store_q.size() != 0) begin n_fail++; $display("FAIL %s_store_seen: got %0d pending, required 0", name, store_q.size()); end
    store_q.delete();
    tick(); tick(); tick();
  endtask

  task automatic test_add();
    run_traced(mk_instr(3'd1, 4'd3, 4'd1, 4'd2, 3'd0), 1'b1, 1'b0, "add");
    run_traced(mk_instr(3'd2, 4'd9, 4'd5, 4'b1010, 3'b101), 1'b1, 1'b0, "addi");
    run_traced(mk_instr(3'd0, 4'd15, 4'd0, 4'd0, 3'b111), 1'b1, 1'b0, "load");
  endtask

  task automatic test_clear_display();
    run_traced(mk_instr(3'd6, 4'd4, 4'd0, 4'd0, 3'd0), 1'b0, 1'b1, "clear");
    run_traced(mk_instr(3'd7, 4'd6, 4'd2, 4'd0, 3'd0), 1'b0, 1'b0, "display");
  endtask

  task automatic test_back_to_back();
    int n_dec;
    logic [2:0] prev;
    bit ok;
    // Held button: exactly one instruction
    instr = mk_instr(3'd3, 4'd7, 4'd1, 4'd2, 3'd0);
    store_q.push_back({1'b1, 1'b0, 4'd7});
    send = 1'b1;
    n_dec = 0; prev = stateCPU;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (stateCPU == S_DECODE && prev != S_DECODE) n_dec++;
      prev = stateCPU;
    end
    n_checks++;
    if (n_dec != 1 || stateCPU !== S_FETCH) begin
      n_fail++; $display("FAIL hold_send: got %0d decodes, st=%0d, required 1 decode, st=1", n_dec, stateCPU);
    end
    send = 1'b0;
    tick(); tick(); tick();
    // Second press arrives while CALC is stalled
    calc_stuck = 1'b1;
    instr = mk_instr(3'd5, 4'd2, 4'd3, 4'd4, 3'd0);
    store_q.push_back({1'b1, 1'b0, 4'd2});
    send = 1'b1;
    wait_state(S_CALC, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL press_reach_calc: got st=%0d, required 4", stateCPU); end
    send = 1'b0;
    tick(); tick();
    send = 1'b1;
    tick(); tick(); tick(); tick();
    send = 1'b0;
    calc_stuck = 1'b0;
    wait_state(S_FETCH, 20, ok);
    n_dec = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stateCPU != S_FETCH) n_dec++;
    end
    n_checks++;
    if (!ok || n_dec != 0) begin
      n_fail++; $display("FAIL press_in_calc_ignored: got %0d non-FETCH cycles, required 0", n_dec);
    end
    n_checks++;
    if (store_q.size() != 0) begin n_fail++; $display("FAIL back_to_back_stores: got %0d pending, required 0", store_q.size()); end
    store_q.delete();
  endtask

  task automatic test_power_off();
    bit ok;
    int bad;
    instr = mk_instr(3'd4, 4'd11, 4'd1, 4'd0, 3'd3);
    send = 1'b1;
    wait_state(S_READ, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwr_reach_read: got st=%0d, required 3", stateCPU); end
    power = 1'b0;
    tick();
    n_checks++;
    if (stateCPU !== S_OFF || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL pwr_off_now: got st=%0d we=%0b, required st=0 we=0", stateCPU, ram_we);
    end
    send = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (stateCPU !== S_OFF || opcode !== 3'd4 || addr_dst !== 4'd11) begin
      n_fail++; $display("FAIL pwr_off_hold: got st=%0d op=%0d dst=%0d, required st=0 op=4 dst=11", stateCPU, opcode, addr_dst);
    end
    power = 1'b1;
    tick();
    n_checks++;
    if (stateCPU !== S_FETCH) begin n_fail++; $display("FAIL pwr_on_fetch: got %0d, required 1", stateCPU); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stateCPU != S_FETCH) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL pwr_await_send: got %0d non-FETCH cycles, required 0", bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    int bad;
    calc_stuck = 1'b1;
    instr = mk_instr(3'd1, 4'd5, 4'd1, 4'd1, 3'd0);
    send = 1'b1;
    wait_state(S_CALC, 20, ok);
    send = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_reach_calc: got st=%0d, required 4", stateCPU); end
    bad = 0;
`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      tick();
      if (stateCPU != S_CALC || err != 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL to_calc_hold: got %0d early exits, required 0", bad); end
    tick();
    n_checks++;
    if (stateCPU !== S_FETCH || err !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL to_expire: got st=%0d err=%0b we=%0b, required st=1 err=1 we=0", stateCPU, err, ram_we);
    end
    tick(); tick();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got err=%0b, required 1", err); end
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (stateCPU != S_CALC || err != 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_timeout_hold: got %0d cycles off CALC or err, required 0", bad); end
`endif
    power = 1'b0;
    tick();
    n_checks++;
    if (stateCPU !== S_OFF || err !== 1'b0) begin
      n_fail++; $display("FAIL to_power_clear: got st=%0d err=%0b, required st=0 err=0", stateCPU, err);
    end
    calc_stuck = 1'b0;
    power = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    calc_stuck = 1'b1;
    instr = mk_instr(3'd1, 4'd8, 4'd1, 4'd1, 3'd0);
    send = 1'b1;
    wait_state(S_CALC, 20, ok);
    send = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_reach_calc: got st=%0d, required 4", stateCPU); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (stateCPU !== S_OFF || ram_we !== 1'b0 || opcode !== 3'd0 || addr_dst !== 4'd0) begin
      n_fail++; $display("FAIL rst_async: got st=%0d we=%0b op=%0d dst=%0d, required all 0", stateCPU, ram_we, opcode, addr_dst);
    end
    calc_stuck = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (stateCPU !== S_FETCH) begin n_fail++; $display("FAIL rst_recover: got %0d, required 1", stateCPU); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_clear_display();
    test_back_to_back();
    test_power_off();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
